// File: rtl/booth_pkg.sv
// booth_pkg: shared states, Booth op encoding and default width for the Booth multiplier
package booth_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {NOP, ADD, SUB} op_e;
  function automatic op_e booth_op(input logic q0, input logic q_1);
    return {q0, q_1} == 2'b01 ? ADD : {q0, q_1} == 2'b10 ? SUB : NOP;
  endfunction
endpackage

// File: rtl/booth_seq_multiplier_if.sv
// booth_seq_multiplier_if: start request, operands and result/status of the Booth multiplier
interface booth_seq_multiplier_if import booth_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] y;
  logic done;
  logic busy;
  modport master (output valid, a, b, input y, done, busy);
  modport slave (input valid, a, b, output y, done, busy);
endinterface

// File: rtl/booth_down_counter.sv
// booth_down_counter: loadable iteration down-counter with combinational zero flag
module booth_down_counter #(parameter int CNT_W = 2) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] load_val,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  // load wins over decrement
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth signed multiplier; BOOTH_ZERO_BYPASS_EN skips the iterations for zero operands
module booth_seq_multiplier import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  booth_seq_multiplier_if.slave bus
);
  state_e state;
  logic [WIDTH:0] m, hq, sum;
  logic [WIDTH-1:0] q;
  logic q_1, accept, bypass, cnt_zero;
  logic [CNT_W-1:0] cnt;
  op_e op;
  assign accept = state == IDLE && bus.valid;
`ifdef BOOTH_ZERO_BYPASS_EN
  assign bypass = accept && (bus.a == '0 || bus.b == '0);
`else
  assign bypass = 1'b0;
`endif
  assign op = booth_op(q[0], q_1);
  assign sum = op == ADD ? hq + m : op == SUB ? hq - m : hq;
  booth_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load_val(CNT_W'(WIDTH - 1)), .load(accept && !bypass),
    .dec(state == SHIFT && cnt != '0), .count(cnt), .zero(cnt_zero)
  );
  // controller and shift/add-subtract datapath; outputs are registered
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      m <= '0;
      hq <= '0;
      q <= '0;
      q_1 <= 1'b0;
      bus.y <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.valid) begin
            m <= {bus.a[WIDTH-1], bus.a};
            q <= bypass ? '0 : bus.b;
            hq <= '0;
            q_1 <= 1'b0;
            bus.busy <= 1'b1;
            state <= bypass ? DONE : EVAL;
          end
        end
        EVAL: begin
          hq <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          {hq, q, q_1} <= {hq[WIDTH], hq, q};
          state <= cnt_zero ? DONE : EVAL;
        end
        DONE: begin
          bus.y <= {hq[WIDTH-1:0], q};
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: directed checks of products, latency, ignored requests and reset abort
module tb_booth_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] last_y = 8'h00;
  int zlat;
  booth_seq_multiplier_if #(.WIDTH(4)) bus ();
  booth_seq_multiplier #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [3:0] a_i, input logic [3:0] b_i, input logic [7:0] ey,
                    input int elat, input bit noisy, input string tag);
    int cyc = 0;
    @(negedge clk);
    bus.a = a_i;
    bus.b = b_i;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    check({tag, "_busy"}, 16'(bus.busy), 16'd1);
    check({tag, "_yhold"}, 16'(bus.y), 16'(last_y));
    while (!bus.done && cyc < 40) begin
      if (noisy && (cyc == 2 || cyc == 5)) begin
        bus.valid = 1'b1;
        bus.a = 4'd7;
        bus.b = 4'd7;
      end else bus.valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.valid = 1'b0;
    check({tag, "_latency"}, 16'(cyc), 16'(elat));
    check({tag, "_y"}, 16'(bus.y), 16'(ey));
    last_y = ey;
    @(negedge clk);
    check({tag, "_done_width"}, 16'(bus.done), 16'd0);
    check({tag, "_busy_end"}, 16'(bus.busy), 16'd0);
  endtask
  initial begin
    int dones;
    bus.valid = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
`ifdef BOOTH_ZERO_BYPASS_EN
    zlat = 1;
`else
    zlat = 9;
`endif
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_y", 16'(bus.y), 16'h0);
    check("reset_done", 16'(bus.done), 16'h0);
    check("reset_busy", 16'(bus.busy), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    op(4'd3, 4'd5, 8'h0F, 9, 1'b0, "p3x5");
    repeat (3) @(negedge clk);
    check("idle_hold_y", 16'(bus.y), 16'h0F);
    op(4'hD, 4'd5, 8'hF1, 9, 1'b0, "m3x5");
    op(4'd5, 4'hD, 8'hF1, 9, 1'b0, "p5xm3");
    op(4'h8, 4'h8, 8'h40, 9, 1'b0, "m8xm8");
    op(4'd7, 4'h8, 8'hC8, 9, 1'b0, "p7xm8");
    op(4'h8, 4'd1, 8'hF8, 9, 1'b0, "m8x1");
    op(4'd2, 4'd3, 8'h06, 9, 1'b1, "noisy2x3");
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_second_done", 16'(dones), 16'd0);
    @(negedge clk);
    bus.a = 4'd3;
    bus.b = 4'd5;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_y", 16'(bus.y), 16'h0);
    check("abort_done", 16'(bus.done), 16'h0);
    check("abort_busy", 16'(bus.busy), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    last_y = 8'h00;
    op(4'hF, 4'hF, 8'h01, 9, 1'b0, "m1xm1");
    op(4'd0, 4'd6, 8'h00, zlat, 1'b0, "z0x6");
    op(4'd5, 4'd0, 8'h00, zlat, 1'b0, "z5x0");
    op(4'd6, 4'd7, 8'h2A, 9, 1'b0, "p6x7");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands.
- Contains an FSM controller, a shift/add-subtract datapath and a down-counter that tracks iterations.
- One multiply per `valid` pulse; the result is held on `y` until the next accepted start.
- Sits behind the input synchronizer/register stage and drives the result display path.

Parameters:
- WIDTH, 4, operand width in bits (≥2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  start request; sampled only in IDLE.
- a  input  WIDTH  signed multiplicand.
- b  input  WIDTH  signed multiplier.
- y  output  2*WIDTH  signed product {HQ,Q}.
- done  output  1  one-cycle pulse when `y` is final.
- busy  output  1  high from the cycle after acceptance until DONE is left.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst=0: state=IDLE; M, HQ, Q, Q_1, counter, y all 0; done=0, busy=0.
- Datapath registers:
  - M: WIDTH+1 bits, sign-extended a.
  - HQ: WIDTH+1 bits, accumulator; the extra bit keeps -2^(W-1) operands correct.
  - Q: WIDTH bits, multiplier.
  - Q_1: 1 bit.
- States: IDLE, EVAL, SHIFT, DONE.
- IDLE, valid=1:
  - M <= sext(a), Q <= b, HQ <= 0, Q_1 <= 0, counter <= WIDTH-1.
  - Next state EVAL. valid=0: stay.
- EVAL, case {Q[0],Q_1}:
  - 01: HQ <= HQ+M.
  - 10: HQ <= HQ-M.
  - 00 or 11: hold.
  - Always go to SHIFT.
- SHIFT:
  - Arithmetic right shift of {HQ,Q,Q_1} by one; HQ MSB replicated.
  - If counter==0: go to DONE. Else counter <= counter-1 and go to EVAL.
- DONE:
  - y <= {HQ[WIDTH-1:0],Q}, visible in the same cycle as the done pulse.
  - done=1 for exactly this cycle; next state IDLE.
- Iterations: exactly WIDTH EVAL/SHIFT pairs.
- Latency: done is high 2*WIDTH+1 cycles after the accepting edge (9 for WIDTH=4).
- valid while busy or in DONE is ignored; no queuing.
- a and b are captured only at acceptance; later changes have no effect.
- y holds its value through IDLE and the next operation until that operation's DONE.
- Counter asserts zero-flag combinationally when count==0. Load has priority over decrement.
- Reset mid-operation aborts immediately to reset values; the next valid starts cleanly.
- Product fits 2*WIDTH bits for all operand pairs, e.g. (-8)*(-8)=+64 for WIDTH=4.

Optional Feature:
- Macro BOOTH_ZERO_BYPASS_EN.
- Defined: in IDLE with valid=1 and (a==0 or b==0), go directly to DONE with HQ=0, Q=0. Result: y=0, done one cycle after acceptance, counter untouched.
- Undefined: zero operands take the full 2*WIDTH+1 cycle path with the same y=0 result.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, EVAL, SHIFT, DONE}.
  - Booth op encoding {NOP, ADD, SUB} derived from {Q0,Q_1}.
  - Default WIDTH constant.
- Sub-module booth_down_counter:
  - Inputs: load value, load, decrement.
  - Outputs: count, zero flag.
  - Async active-low reset.
- FSM and datapath stay in the top module.

Test Plan (WIDTH=4):
- a=3, b=5, valid pulse → y=8'h0F; done high exactly 9 cycles after acceptance, one cycle wide.
- a=-3 (4'hD), b=5 → y=8'hF1 (-15); a=5, b=-3 → 8'hF1.
- a=-8, b=-8 → y=8'h40 (+64); a=7, b=-8 → y=8'hC8 (-56).
- Extra valid pulses and changes to a/b mid-operation after a=2, b=3 → y=8'h06, no second done.
- rst=0 at cycle 4 of an operation → y=0, done=0, busy=0 immediately; then a=-1, b=-1 → y=8'h01.
- With BOOTH_ZERO_BYPASS_EN: a=0, b=6 → y=0, done 1 cycle after acceptance; without the macro → done after 9 cycles.
